mul_seq_param: RTL and testbench

- Parametrised sequential shift-add multiplier. It is the next generation of the 8-bit signed sequential multiplier.
- Adds a generic operand width, a per-operation signed/unsigned mode select and an explicit start/ready/done handshake.
- Sits beside the datapath blocks as a low-area multi-cycle multiplier. It processes one operation at a time.

---
 rtl/mul_seq_param.sv | 70 +++++++
 tb/tb_mul_seq_param.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/mul_seq_param.sv
// mul_seq_param: shift-add sequential multiplier, signed/unsigned per operation, start/ready/done handshake
module mul_seq_param #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH+1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] y,
  output logic               ready,
  output logic               done
);
  localparam logic [1:0] IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2, DONE = 2'd3;
  logic [1:0]           state;
  logic [WIDTH-1:0]     mcand;
  logic [2*WIDTH:0]     acc;
  logic [CNT_W-1:0]     cnt;
  logic                 sgn;
  logic [WIDTH-1:0]     mag_a, mag_b;
  logic [WIDTH:0]       sum;
  logic [2*WIDTH-1:0]   prod;
  always_comb begin
    mag_a = (signed_mode && a[WIDTH-1]) ? -a : a;
    mag_b = (signed_mode && b[WIDTH-1]) ? -b : b;
    sum   = acc[2*WIDTH:WIDTH] + {1'b0, mcand & {WIDTH{acc[0]}}};
    prod  = acc[2*WIDTH-1:0];
  end
  // multiplier sits in the low half and is consumed LSB-first as the partial product shifts in
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      mcand <= '0;
      acc   <= '0;
      cnt   <= '0;
      sgn   <= 1'b0;
      y     <= '0;
      done  <= 1'b0;
      ready <= 1'b1;
    end else begin
      case (state)
        IDLE: if (start) begin
          mcand <= mag_a;
          acc   <= {{(WIDTH+1){1'b0}}, mag_b};
          cnt   <= '0;
          sgn   <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
          ready <= 1'b0;
          state <= CALC;
        end
        CALC: begin
          acc   <= {sum, acc[WIDTH-1:0]} >> 1;
          cnt   <= cnt + 1'b1;
          state <= (cnt == CNT_W'(WIDTH-1)) ? FIX : CALC;
        end
        FIX: begin
          y     <= sgn ? -prod : prod;
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          ready <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mul_seq_param.sv
// tb_mul_seq_param: scoreboard bench for the 8- and 16-bit sequential multiplier
module tb_mul_seq_param;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic        start8 = 1'b0, sm8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [15:0] y8;
  logic        ready8, done8;
  logic        start16 = 1'b0, sm16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic [31:0] y16;
  logic        ready16, done16;
  int n_checks = 0, n_fail = 0;
  logic [15:0] q8[$];
  logic [31:0] q16[$];

  mul_seq_param #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .start(start8), .signed_mode(sm8),
    .a(a8), .b(b8), .y(y8), .ready(ready8), .done(done8));
  mul_seq_param #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .start(start16), .signed_mode(sm16),
    .a(a16), .b(b16), .y(y16), .ready(ready16), .done(done16));

  function automatic logic [15:0] model8(input logic m, input logic [7:0] x, input logic [7:0] z);
    logic [15:0] ex, ez;
    ex = m ? {{8{x[7]}}, x} : {8'h00, x};
    ez = m ? {{8{z[7]}}, z} : {8'h00, z};
    return ex * ez;
  endfunction

  task automatic op8(input logic m, input logic [7:0] x, input logic [7:0] z, input logic [15:0] exp);
    int lat;
    logic [15:0] want;
    @(negedge clk);
    sm8 = m; a8 = x; b8 = z; start8 = 1'b1;
    q8.push_back(exp);
    @(negedge clk);
    start8 = 1'b0; a8 = ~x; b8 = ~z; sm8 = ~m;
    lat = 0;
    while (!done8 && lat < 40) begin @(negedge clk); lat++; end
    want = q8.pop_front();
    n_checks++;
    if (!done8) begin n_fail++; $display("FAIL op8_timeout %h*%h: no done after %0d cycles", x, z, lat); end
    else if (y8 !== want) begin n_fail++; $display("FAIL op8_y m=%0b %h*%h: got %h want %h", m, x, z, y8, want); end
    n_checks++;
    if (lat !== 9) begin n_fail++; $display("FAIL op8_latency: got %0d want 9", lat); end
    @(negedge clk);
    n_checks++;
    if (done8 !== 1'b0 || ready8 !== 1'b1) begin
      n_fail++; $display("FAIL op8_after_done: done=%b ready=%b want done=0 ready=1", done8, ready8);
    end
  endtask

  task automatic op16(input logic m, input logic [15:0] x, input logic [15:0] z, input logic [31:0] exp);
    int lat;
    logic [31:0] want;
    @(negedge clk);
    sm16 = m; a16 = x; b16 = z; start16 = 1'b1;
    q16.push_back(exp);
    @(negedge clk);
    start16 = 1'b0; a16 = '0; b16 = '0;
    lat = 0;
    while (!done16 && lat < 60) begin @(negedge clk); lat++; end
    want = q16.pop_front();
    n_checks++;
    if (!done16) begin n_fail++; $display("FAIL op16_timeout %h*%h: no done", x, z); end
    else if (y16 !== want) begin n_fail++; $display("FAIL op16_y %h*%h: got %h want %h", x, z, y16, want); end
    n_checks++;
    if (lat !== 17) begin n_fail++; $display("FAIL op16_latency: got %0d want 17", lat); end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    n_checks++;
    if (y8 !== 16'h0 || ready8 !== 1'b1 || done8 !== 1'b0 || y16 !== 32'h0 || ready16 !== 1'b1) begin
      n_fail++; $display("FAIL reset_state: y8=%h r8=%b d8=%b y16=%h r16=%b", y8, ready8, done8, y16, ready16);
    end
    rst = 1'b0;
  endtask

  task automatic test_signed;
    op8(1'b1, 8'hFB, 8'h07, 16'hFFDD);
    op8(1'b1, 8'hF6, 8'hF6, 16'h0064);
    op8(1'b1, 8'h7F, 8'hFF, 16'hFF81);
    op8(1'b1, 8'h80, 8'h80, 16'h4000);
    op8(1'b1, 8'h00, 8'hFD, 16'h0000);
  endtask

  task automatic test_unsigned;
    op8(1'b0, 8'hFF, 8'hFF, 16'hFE01);
    op8(1'b0, 8'h80, 8'h02, 16'h0100);
    op8(1'b0, 8'hFF, 8'h07, 16'h06F9);
    op8(1'b1, 8'hFF, 8'h07, 16'hFFF9);
  endtask

  task automatic test_back_to_back;
    int ndone = 0, last_done = -1;
    logic prev_done = 1'b0;
    logic [15:0] last_y, want;
    @(negedge clk);
    last_y = y8;
    start8 = 1'b1; sm8 = 1'b1; a8 = 8'($urandom); b8 = 8'($urandom);
    if (ready8) q8.push_back(model8(sm8, a8, b8));
    for (int c = 1; c <= 45; c++) begin
      @(negedge clk);
      n_checks++;
      if (done8) begin
        want = (q8.size() > 0) ? q8.pop_front() : ~y8;
        if (y8 !== want) begin n_fail++; $display("FAIL b2b_y cycle %0d: got %h want %h", c, y8, want); end
        n_checks++;
        if (prev_done) begin n_fail++; $display("FAIL b2b_pulse_width cycle %0d: done high 2 cycles", c); end
        if (last_done >= 0) begin
          n_checks++;
          if (c - last_done != 11) begin n_fail++; $display("FAIL b2b_spacing: got %0d want 11", c - last_done); end
        end
        last_done = c; ndone++; last_y = y8;
      end else if (y8 !== last_y) begin
        n_fail++; $display("FAIL b2b_stable cycle %0d: got %h want %h", c, y8, last_y);
      end
      prev_done = done8;
      if (c < 30) begin
        a8 = 8'($urandom); b8 = 8'($urandom); sm8 = 1'($urandom);
        if (ready8) q8.push_back(model8(sm8, a8, b8));
      end else start8 = 1'b0;
    end
    n_checks++;
    if (q8.size() != 0 || ndone != 3) begin
      n_fail++; $display("FAIL b2b_count: done pulses %0d want 3, pending %0d want 0", ndone, q8.size());
    end
    q8.delete();
  endtask

  task automatic test_reset_mid;
    int nd = 0;
    @(negedge clk);
    sm8 = 1'b0; a8 = 8'h09; b8 = 8'h09; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (y8 !== 16'h0 || ready8 !== 1'b1 || done8 !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset: y=%h ready=%b done=%b want 0/1/0", y8, ready8, done8);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (15) begin @(negedge clk); if (done8) nd++; end
    n_checks++;
    if (nd != 0) begin n_fail++; $display("FAIL mid_reset_no_done: got %0d pulses want 0", nd); end
    op8(1'b0, 8'h06, 8'h07, 16'h002A);
  endtask

  task automatic test_width16;
    op16(1'b1, 16'h8000, 16'h8000, 32'h40000000);
    op16(1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001);
    op16(1'b1, 16'hFFFB, 16'h0007, 32'hFFFFFFDD);
  endtask

  initial begin
    test_reset;
    test_signed;
    test_unsigned;
    test_back_to_back;
    test_reset_mid;
    test_width16;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
